// File: rtl/ps2_pkg.sv
// Shared constants, event layout and receiver state encoding for the PS/2 frame receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EV_W        = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_CODE_MSB = 7;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_e;

    function automatic logic [EV_W-1:0] pack_event(input logic ext, input logic brk,
                                                   input logic [7:0] code);
        return {ext, brk, code};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO with occupancy count and a drop strobe
// for pushes that find the FIFO full with no simultaneous pop.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// System-clock PS/2 receiver: sync + glitch filter, 11-bit deframing with
// odd-parity check, E0/F0 prefix folding, and a valid/ready event FIFO.
//   state    | meaning
//   ST_IDLE  | waiting for a falling edge with data low (start bit)
//   ST_SHIFT | collecting data bits 1-8, parity (9), stop (10); timeout armed
//   ST_CHECK | one cycle: validate frame, fold prefix or push event
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ps2_clk,
    input  logic                        i_ps2_data,
    output logic                        o_ev_valid,
    input  logic                        i_ev_ready,
    output logic [7:0]                  o_ev_code,
    output logic                        o_ev_break,
    output logic                        o_ev_ext,
    output logic                        o_frame_err,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYC) + 1;

    logic           r_clk_s1;
    logic           r_clk_s2;
    logic           r_dat_s1;
    logic           r_dat_s2;
    logic           r_filt;
    logic [FCW-1:0] r_fcnt;
    logic           r_fall;

    ps2_state_e     r_state;
    logic [3:0]     r_bitcnt;
    logic [TCW-1:0] r_tocnt;
    logic [7:0]     r_shift;
    logic           r_par;
    logic           r_stop;
    logic           r_ext_pend;
    logic           r_brk_pend;
    logic           r_frame_err;
    logic           r_overflow;

    logic            w_frame_ok;
    logic            w_is_prefix;
    logic            w_push;
    logic            w_drop;
    logic            w_empty;
    logic [EV_W-1:0] w_event;
    logic [EV_W-1:0] w_head;

    // Synchronise both lines; the filtered clock only flips after FILTER_LEN
    // consecutive synced samples disagree with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
            r_fall   <= 1'b0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                    r_fall <= r_filt;
                end else begin
                    r_fcnt <= r_fcnt + FCW'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_frame_ok  = (^{r_shift, r_par}) && r_stop;
    assign w_is_prefix = (r_shift == PS2_EXT) || (r_shift == PS2_BRK);
    assign w_push      = (r_state == ST_CHECK) && w_frame_ok && !w_is_prefix;
    assign w_event     = pack_event(r_ext_pend, r_brk_pend, r_shift);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_tocnt     <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_stop      <= 1'b0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tocnt <= '0;
                    if (r_fall && !r_dat_s2) begin
                        r_state  <= ST_SHIFT;
                        r_bitcnt <= 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (r_fall) begin
                        r_tocnt  <= '0;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt <= 4'd8) begin
                            r_shift <= {r_dat_s2, r_shift[7:1]};
                        end else if (r_bitcnt == 4'd9) begin
                            r_par <= r_dat_s2;
                        end else begin
                            r_stop  <= r_dat_s2;
                            r_state <= ST_CHECK;
                        end
                    end else if (r_tocnt == TCW'(TIMEOUT_CYC - 1)) begin
                        r_state     <= ST_IDLE;
                        r_tocnt     <= '0;
                        r_bitcnt    <= '0;
                        r_frame_err <= 1'b1;
                        r_ext_pend  <= 1'b0;
                        r_brk_pend  <= 1'b0;
                    end else begin
                        r_tocnt <= r_tocnt + TCW'(1);
                    end
                end
                ST_CHECK: begin
                    r_state  <= ST_IDLE;
                    r_bitcnt <= '0;
                    if (!w_frame_ok) begin
                        r_frame_err <= 1'b1;
                        r_ext_pend  <= 1'b0;
                        r_brk_pend  <= 1'b0;
                    end else if (r_shift == PS2_EXT) begin
                        r_ext_pend <= 1'b1;
                    end else if (r_shift == PS2_BRK) begin
                        r_brk_pend <= 1'b1;
                    end else begin
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_event),
        .i_pop   (i_ev_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (o_fifo_count),
        .o_drop  (w_drop)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_ev_valid  = !w_empty;
    assign o_ev_code   = w_head[EV_CODE_MSB:EV_CODE_LSB];
    assign o_ev_break  = w_head[EV_BRK_BIT];
    assign o_ev_ext    = w_head[EV_EXT_BIT];
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: drives PS/2 frames bit by bit and checks
// events, error pulses, FIFO occupancy and overflow against hand-computed values.
module tb_ps2_frame_rx;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int FIFO_DEPTH  = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    logic [9:0] evq[$];

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_ev_valid   (ev_valid),
        .i_ev_ready   (ev_ready),
        .o_ev_code    (ev_code),
        .o_ev_break   (ev_break),
        .o_ev_ext     (ev_ext),
        .o_frame_err  (frame_err),
        .o_overflow   (overflow),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Consumed events and error pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_break, ev_code});
        if (frame_err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(20);
        ps2_clk = 1'b1;
        if (glitch) begin
            cycles(12);
            ps2_clk = 1'b0;
            cycles(FILTER_LEN - 1);
            ps2_clk = 1'b1;
            cycles(10);
        end else begin
            cycles(10);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
        send_bit((~^b) ^ bad_par, 1'b0);
        send_bit(1'b1, 1'b0);
        cycles(10);
    endtask

    initial begin
        int e0;
        logic [7:0] b;

        // Reset state
        cycles(3);
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_code", ev_code, 8'h00);
        chk("rst_flags", {ev_break, ev_ext, frame_err, overflow}, 4'b0000);
        chk("rst_count", fifo_count, 4'd0);
        rst = 1'b0;
        cycles(5);

        // Single valid 0x1C with stop-edge to ev_valid latency
        ev_ready = 1'b1;
        evq.delete();
        e0 = err_cnt;
        b = 8'h1C;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(7);
        chk("t1_valid_early", ev_valid, 1'b0);
        cycles(1);
        chk("t1_valid_on_time", ev_valid, 1'b1);
        chk("t1_code", ev_code, 8'h1C);
        cycles(12);
        ps2_clk = 1'b1;
        cycles(20);
        chk("t1_n_events", evq.size(), 1);
        chk("t1_event", evq[0], 10'h01C);
        chk("t1_no_err", err_cnt - e0, 0);

        // Break and extended-break prefixes
        evq.delete();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        cycles(5);
        chk("t2_brk_n", evq.size(), 1);
        chk("t2_brk_ev", evq[0], 10'h11C);
        evq.delete();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        cycles(5);
        chk("t2_extbrk_n", evq.size(), 1);
        chk("t2_extbrk_ev", evq[0], 10'h375);

        // Parity error then a good frame
        evq.delete();
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h2A, 1'b0, 1'b0);
        cycles(5);
        chk("t3_err_pulses", err_cnt - e0, 1);
        chk("t3_n_events", evq.size(), 1);
        chk("t3_event", evq[0], 10'h02A);

        // Timeout after 5 bits, then recovery
        evq.delete();
        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        cycles(TIMEOUT_CYC + 50);
        chk("t4_timeout_err", err_cnt - e0, 1);
        chk("t4_no_event", evq.size(), 0);
        send_frame(8'h29, 1'b0, 1'b0);
        cycles(5);
        chk("t4_recover_n", evq.size(), 1);
        chk("t4_recover_ev", evq[0], 10'h029);
        chk("t4_err_total", err_cnt - e0, 1);

        // Short clock glitch mid-frame is filtered out
        evq.delete();
        e0 = err_cnt;
        send_frame(8'h3A, 1'b0, 1'b1);
        cycles(5);
        chk("t6_glitch_n", evq.size(), 1);
        chk("t6_glitch_ev", evq[0], 10'h03A);
        chk("t6_glitch_err", err_cnt - e0, 0);

        // Overflow with consumer stalled, then drain in order
        ev_ready = 1'b0;
        evq.delete();
        send_frame(8'h10, 1'b0, 1'b0);
        chk("t5_head_first", ev_code, 8'h10);
        for (int k = 1; k < 9; k++) send_frame(8'h10 + 8'(k), 1'b0, 1'b0);
        chk("t5_count_full", fifo_count, 4'd8);
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_head_held", ev_code, 8'h10);
        chk("t5_no_pop", evq.size(), 0);
        ev_ready = 1'b1;
        cycles(20);
        chk("t5_drain_n", evq.size(), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("t5_drain_%0d", k), evq[k], 10'h010 + 10'(k));
        chk("t5_empty", ev_valid, 1'b0);
        chk("t5_count_zero", fifo_count, 4'd0);
        chk("t5_ovf_sticky", overflow, 1'b1);

        // Reset in the middle of a frame
        evq.delete();
        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        cycles(2);
        chk("t7_rst_ovf", overflow, 1'b0);
        chk("t7_rst_valid", ev_valid, 1'b0);
        chk("t7_rst_count", fifo_count, 4'd0);
        rst = 1'b0;
        cycles(200);
        chk("t7_no_event", evq.size(), 0);
        chk("t7_no_err", err_cnt - e0, 0);
        send_frame(8'h5A, 1'b0, 1'b0);
        cycles(5);
        chk("t7_after_n", evq.size(), 1);
        chk("t7_after_ev", evq[0], 10'h05A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
System-clock PS/2 receiver placed upstream of the keyboard decode/ASCII stage. It replaces direct use of ps2_clk as a clock with the following pipeline:
- synchronise and glitch-filter the PS/2 lines;
- deframe 11-bit frames and check start, odd parity and stop;
- fold E0/F0 prefixes into flags on the following scan code;
- queue events in a FIFO with a valid/ready handshake for the decode stage.

Parameters:
FILTER_LEN, 4, consecutive equal clk samples needed to change the filtered ps2_clk level
TIMEOUT_CYC, 50000, clk cycles without a falling edge before a partial frame is aborted
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ps2_clk  in  1  raw PS/2 clock line, asynchronous
ps2_data  in  1  raw PS/2 data line, asynchronous
ev_valid  out  1  FIFO non-empty; head event presented
ev_ready  in  1  consumer accepts head event
ev_code  out  8  scan code of head event
ev_break  out  1  head event was preceded by F0
ev_ext  out  1  head event was preceded by E0
frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error
overflow  out  1  sticky: an event was dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Clocking and reset: one clock. rst is asynchronous and active-high.
- Reset values:
  - all outputs 0;
  - sync flops and filtered clock level 1;
  - FSM in IDLE;
  - bit counter 0, timeout counter 0;
  - prefix flags clear, FIFO empty.
- Synchroniser: 2-FF synchroniser on both lines.
- Filter: the filtered clock goes 0 after FILTER_LEN consecutive synced 0s, and 1 after FILTER_LEN consecutive 1s. A falling edge is a filtered 1->0 transition, flagged for one cycle; the synced data is sampled in that same cycle.
- FSM IDLE: on a falling edge with data=0, go to SHIFT with bitcnt=1. A falling edge with data=1 is ignored (no error).
- FSM SHIFT: each falling edge stores the bit.
  - bits 1-8 are data, LSB first; bit 9 is parity; bit 10 is stop;
  - after bit 10, go to CHECK.
- FSM CHECK (1 cycle), then back to IDLE:
  - frame OK when XOR(data, parity)=1 and stop=1;
  - OK frame: the byte goes to the prefix logic;
  - bad frame: frame_err=1 for 1 cycle, byte discarded, prefix flags cleared.
- Timeout:
  - in SHIFT the counter increments every cycle and clears on each falling edge;
  - reaching TIMEOUT_CYC-1: go to IDLE, frame_err pulse, prefix flags cleared;
  - the counter is idle outside SHIFT.
- Prefix logic:
  - E0 sets ext_pend; F0 sets brk_pend; neither is pushed;
  - any other byte (including E1, AA, FA, EE) pushes {ext_pend, brk_pend, byte} and clears both flags.
- Latency: stop-bit edge flagged in cycle N -> CHECK in N+1 writes the FIFO -> ev_valid=1 in N+2 when the FIFO was empty.
- FIFO:
  - first-word fall-through;
  - pop when ev_valid&&ev_ready;
  - ev_code/ev_break/ev_ext hold stable while ev_valid=1 and ev_ready=0.
- FIFO full:
  - push dropped and overflow set, held until rst;
  - push and pop in the same cycle when full: both happen, no overflow;
  - push and pop when empty: push only, since pop requires ev_valid.
- Reset mid-frame: partial frame and flags discarded immediately. Nothing is emitted for the remaining bits until a new start bit arrives in IDLE; residual edges with data=0 may resync and later fail the checks.

Decomposition:
- Package ps2_pkg:
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0;
  - event width 10 with field offsets (code[7:0], brk[8], ext[9]);
  - FSM state encodings IDLE/SHIFT/CHECK.
- Sub-module ps2_event_fifo: parameterised FWFT FIFO with count, full/empty, and a drop-on-full strobe feeding overflow. The rest lives in ps2_frame_rx.

Test Plan:
- Valid frame 0x1C (parity 0, stop 1), ev_ready=1 -> one event, code=1C, brk=0, ext=0; ev_valid 2 cycles after the stop edge; frame_err never set.
- Frames F0, 1C -> exactly one event, code=1C, brk=1, ext=0. Frames E0, F0, 75 -> one event, code=75, brk=1, ext=1.
- 0x1C frame with wrong parity, then a good 0x2A -> frame_err pulses once; only event is code=2A.
- Send 5 bits then idle TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE. Next full frame 0x29 received as code=29.
- ev_ready=0, send 9 valid frames -> fifo_count=8, overflow=1. Drain -> first 8 codes in order, then ev_valid=0.
- ps2_clk low glitch of FILTER_LEN-1 cycles mid-frame -> no bit taken; the frame still decodes correctly. Assert rst mid-frame -> outputs 0, no event.
